// File: rtl/ws2812_rx_if.sv
// Decoded-pixel bus of the WS2812 one-wire receiver.
// The master side is the receiver: it samples din and drives the pixel stream.
interface ws2812_rx_if;
  logic        din;
  logic [23:0] pixel;
  logic        pixel_valid;
  logic [7:0]  pixel_idx;
  logic        frame_done;
  logic        err;

  modport master (
    input  din,
    output pixel,
    output pixel_valid,
    output pixel_idx,
    output frame_done,
    output err
  );

  modport slave (
    output din,
    input  pixel,
    input  pixel_valid,
    input  pixel_idx,
    input  frame_done,
    input  err
  );
endinterface

// File: rtl/ws2812_rx.sv
// WS2812 one-wire receiver: measures high pulses on the synchronized line,
// assembles 24-bit GRB words, and detects the end-of-frame latch gap.
module ws2812_rx #(
  parameter int unsigned T_MIN_HIGH = 2,
  parameter int unsigned T_THRESH   = 8,
  parameter int unsigned T_MAX_HIGH = 20,
  parameter int unsigned T_LATCH    = 600
) (
  input  logic        clk,
  input  logic        rst_n,
  ws2812_rx_if.master bus
);

  localparam int unsigned HIGH_W = $clog2(T_MAX_HIGH + 2);
  localparam int unsigned LOW_W  = $clog2(T_LATCH + 1);

  localparam logic [HIGH_W-1:0] HIGH_ONE   = HIGH_W'(1);
  localparam logic [HIGH_W-1:0] HIGH_MIN   = HIGH_W'(T_MIN_HIGH);
  localparam logic [HIGH_W-1:0] HIGH_THR   = HIGH_W'(T_THRESH);
  localparam logic [HIGH_W-1:0] HIGH_LIMIT = HIGH_W'(T_MAX_HIGH);
  localparam logic [HIGH_W-1:0] HIGH_SAT   = HIGH_W'(T_MAX_HIGH + 1);
  localparam logic [LOW_W-1:0]  LOW_ONE    = LOW_W'(1);
  localparam logic [LOW_W-1:0]  LOW_LATCH  = LOW_W'(T_LATCH);
  localparam logic [4:0]        WORD_BITS  = 5'd24;
  localparam logic [7:0]        WORD_SAT   = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  logic              din_meta_q, din_meta_d;
  logic              din_s_q, din_s_d;
  state_e            state_q, state_d;
  logic [HIGH_W-1:0] high_cnt_q, high_cnt_d;
  logic [LOW_W-1:0]  low_cnt_q, low_cnt_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [7:0]        word_cnt_q, word_cnt_d;
  logic [23:0]       pixel_q, pixel_d;
  logic              pixel_valid_q, pixel_valid_d;
  logic [7:0]        pixel_idx_q, pixel_idx_d;
  logic              frame_done_q, frame_done_d;
  logic              err_q, err_d;

  always_comb begin
    // NOTE: every _d starts from its hold value (strobes from 0) so no path leaves it unassigned and no latch is inferred.
    din_meta_d    = bus.din;
    din_s_d       = din_meta_q;
    state_d       = state_q;
    high_cnt_d    = high_cnt_q;
    low_cnt_d     = low_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    word_cnt_d    = word_cnt_q;
    pixel_d       = pixel_q;
    pixel_valid_d = 1'b0;
    pixel_idx_d   = pixel_idx_q;
    frame_done_d  = 1'b0;
    err_d         = err_q;

    // The 24th bit landed last cycle: publish the word, then restart bit assembly.
    if (bit_cnt_q == WORD_BITS) begin
      pixel_d       = shift_q;
      pixel_valid_d = 1'b1;
      pixel_idx_d   = word_cnt_q;
      bit_cnt_d     = '0;
      if (word_cnt_q != WORD_SAT) begin
        word_cnt_d = word_cnt_q + 8'd1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (din_s_q) begin
          state_d    = ST_HIGH;
          high_cnt_d = HIGH_ONE;
        end
      end

      ST_HIGH: begin
        if (din_s_q) begin
          if (high_cnt_q != HIGH_SAT) begin
            high_cnt_d = high_cnt_q + HIGH_ONE;
          end
          // Pulse just outgrew the longest legal bit: flag it and drop the partial word.
          if (high_cnt_q == HIGH_LIMIT) begin
            err_d     = 1'b1;
            bit_cnt_d = '0;
          end
        end else if (high_cnt_q == HIGH_SAT) begin
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_LOW;
          low_cnt_d = '0;
          if (high_cnt_q >= HIGH_MIN) begin
            shift_d   = {shift_q[22:0], (high_cnt_q >= HIGH_THR)};
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end

      ST_LOW: begin
        if (low_cnt_q == LOW_LATCH) begin
          // A frame that saw no bits at all ends silently; a partial word leaves err set.
          if ((word_cnt_q != '0) || (bit_cnt_q != '0)) begin
            frame_done_d = 1'b1;
            err_d        = (bit_cnt_q != '0);
          end
          word_cnt_d = '0;
          bit_cnt_d  = '0;
          if (din_s_q) begin
            state_d    = ST_HIGH;
            high_cnt_d = HIGH_ONE;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (din_s_q) begin
          state_d    = ST_HIGH;
          high_cnt_d = HIGH_ONE;
        end else begin
          low_cnt_d = low_cnt_q + LOW_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: the word shift register is reset with the control state so pixel never shows stale bits after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_meta_q    <= 1'b0;
      din_s_q       <= 1'b0;
      state_q       <= ST_IDLE;
      high_cnt_q    <= '0;
      low_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      word_cnt_q    <= '0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
      pixel_idx_q   <= '0;
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values of the others.
      din_meta_q    <= din_meta_d;
      din_s_q       <= din_s_d;
      state_q       <= state_d;
      high_cnt_q    <= high_cnt_d;
      low_cnt_q     <= low_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      word_cnt_q    <= word_cnt_d;
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_idx_q   <= pixel_idx_d;
      frame_done_q  <= frame_done_d;
      err_q         <= err_d;
    end
  end

  assign bus.pixel       = pixel_q;
  assign bus.pixel_valid = pixel_valid_q;
  assign bus.pixel_idx   = pixel_idx_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.err         = err_q;

endmodule
